// File: rtl/adc_frame_writer_pkg.sv
// Shared constants and state encoding for the ADC frame writer.
// Header layout: SYNC0, SYNC1, seq[15:8], seq[7:0].
package adc_frame_pkg;

    localparam logic [7:0] SYNC0     = 8'hA5;
    localparam logic [7:0] SYNC1     = 8'h5A;
    localparam int         HDR_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HDR,
        DATA
    } state_t;

    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [15:0] seq);
        case (idx)
            2'd0:    return SYNC0;
            2'd1:    return SYNC1;
            2'd2:    return seq[15:8];
            default: return seq[7:0];
        endcase
    endfunction

endpackage

// File: rtl/adc_frame_writer_if.sv
// ADC capture inputs and FIFO write-side signals of the frame writer.
// The writer uses the master modport; the FIFO/ADC side uses slave.
interface adc_frame_writer_if #(
    parameter int CNT_W = 11
);
    logic             en_adc;
    logic [7:0]       adc_data;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_wr_count;
    logic [7:0]       fifo_din;
    logic             fifo_wr_en;
    logic [15:0]      frame_seq;
    logic [15:0]      drop_cnt;
    logic             overflow;
    logic             busy;

    modport master (
        input  en_adc, adc_data, fifo_full, fifo_wr_count,
        output fifo_din, fifo_wr_en, frame_seq, drop_cnt, overflow, busy
    );

    modport slave (
        output en_adc, adc_data, fifo_full, fifo_wr_count,
        input  fifo_din, fifo_wr_en, frame_seq, drop_cnt, overflow, busy
    );

endinterface

// File: rtl/adc_frame_writer.sv
// Packs registered ADC samples into fixed-size headered frames and writes them
// to the async FIFO, starting a frame only when the FIFO can hold all of it.
module adc_frame_writer
    import adc_frame_pkg::*;
#(
    parameter int FRAME_BYTES = 1024,
    parameter int FIFO_DEPTH  = 2048,
    parameter int CNT_W       = 11
) (
    input  logic                 clk_32,
    input  logic                 rst,
    adc_frame_writer_if.master   bus
);

    localparam int                BCNT_W    = $clog2(FRAME_BYTES);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(FRAME_BYTES - 1);
    localparam logic [BCNT_W-1:0] LAST_HDR  = BCNT_W'(HDR_BYTES - 1);
    localparam logic [CNT_W:0]    DEPTH_W   = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W:0]    FRAME_W   = (CNT_W + 1)'(FRAME_BYTES);

    state_t            state_q;
    logic [BCNT_W-1:0] byte_cnt_q;
    logic [15:0]       seq_q;
    logic [15:0]       drop_q;
    logic [7:0]        s_reg;
    logic [7:0]        din_q;
    logic              wr_en_q;
    logic              overflow_q;
    logic              busy_q;
    logic              pad_q;

    logic [CNT_W:0]    space;
    logic              space_ok;

    // One extra bit so FIFO_DEPTH itself is representable when the count is 0.
    assign space    = DEPTH_W - {1'b0, bus.fifo_wr_count};
    assign space_ok = !bus.fifo_full && (space >= FRAME_W);

    // NOTE: non-blocking throughout so every branch reads pre-edge register values.
    always_ff @(posedge clk_32 or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= '0;
            seq_q      <= '0;
            drop_q     <= '0;
            s_reg      <= '0;
            din_q      <= '0;
            wr_en_q    <= 1'b0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            pad_q      <= 1'b0;
        end else begin
            s_reg   <= bus.adc_data;
            wr_en_q <= 1'b0;

            // A full FIFO costs the byte but never the slot, so frames keep their length.
            if (state_q == HDR || state_q == DATA) begin
                wr_en_q    <= !bus.fifo_full;
                byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
                if (bus.fifo_full) overflow_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (bus.en_adc) state_q <= WAIT;
                end
                WAIT: begin
                    if (!bus.en_adc) begin
                        state_q <= IDLE;
                    end else if (space_ok) begin
                        state_q    <= HDR;
                        busy_q     <= 1'b1;
                        byte_cnt_q <= '0;
                        pad_q      <= 1'b0;
                    end else if (drop_q != 16'hFFFF) begin
                        drop_q <= drop_q + 16'd1;
                    end
                end
                HDR: begin
                    din_q <= hdr_byte(byte_cnt_q[1:0], seq_q);
                    if (byte_cnt_q == LAST_HDR) state_q <= DATA;
                end
                DATA: begin
                    din_q <= (bus.en_adc && !pad_q) ? s_reg : 8'h00;
                    if (!bus.en_adc) pad_q <= 1'b1;
                    if (byte_cnt_q == LAST_BYTE) begin
                        seq_q      <= seq_q + 16'd1;
                        byte_cnt_q <= '0;
                        pad_q      <= 1'b0;
                        if (bus.en_adc && space_ok) begin
                            state_q <= HDR;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= bus.en_adc ? WAIT : IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.fifo_din   = din_q;
    assign bus.fifo_wr_en = wr_en_q;
    assign bus.frame_seq  = seq_q;
    assign bus.drop_cnt   = drop_q;
    assign bus.overflow   = overflow_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_adc_frame_writer.sv
// Directed bench for adc_frame_writer: header layout, back-to-back frames,
// space gating, zero padding, fifo_full handling, async reset and seq wrap.
module tb_adc_frame_writer;

    localparam int CNT_W = 11;

    logic clk_32 = 1'b0;
    logic rst    = 1'b0;

    adc_frame_writer_if #(.CNT_W(CNT_W)) bus ();

    adc_frame_writer #(
        .FRAME_BYTES(1024),
        .FIFO_DEPTH (2048),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_32(clk_32),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk_32 = ~clk_32;

    int         passed = 0;
    int         total  = 0;
    bit         ramp_on = 1'b0;
    logic [7:0] frm [0:3071];
    logic       wen [0:3071];

    // Advance to the falling edge; the ramp steps once per cycle.
    task automatic step();
        @(negedge clk_32);
        if (ramp_on) bus.adc_data = bus.adc_data + 8'd1;
    endtask

    task automatic apply_reset(input logic [CNT_W-1:0] count);
        rst               = 1'b1;
        ramp_on           = 1'b0;
        bus.en_adc        = 1'b0;
        bus.adc_data      = 8'd0;
        bus.fifo_full     = 1'b0;
        bus.fifo_wr_count = count;
        repeat (2) @(negedge clk_32);
        rst = 1'b0;
    endtask

    task automatic wait_write(output bit found);
        found = 1'b0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (bus.fifo_wr_en === 1'b1) begin
                found = 1'b1;
                return;
            end
        end
    endtask

    task automatic capture(input int n);
        frm[0] = bus.fifo_din;
        wen[0] = bus.fifo_wr_en;
        for (int i = 1; i < n; i++) begin
            step();
            frm[i] = bus.fifo_din;
            wen[i] = bus.fifo_wr_en;
        end
    endtask

    task automatic test_reset();
        bus.en_adc = 1'b0; bus.adc_data = 8'd0; bus.fifo_full = 1'b0; bus.fifo_wr_count = '0;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.fifo_din, bus.fifo_wr_en, bus.frame_seq, bus.drop_cnt, bus.overflow, bus.busy} !== 43'd0)
            $display("FAIL reset_outputs: got din=%h wr_en=%b seq=%h drop=%h ovf=%b busy=%b, expected all zero",
                     bus.fifo_din, bus.fifo_wr_en, bus.frame_seq, bus.drop_cnt, bus.overflow, bus.busy);
        else passed++;
        apply_reset('0);
        repeat (3) step();
        total++;
        if (bus.fifo_wr_en !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL idle_quiet: got wr_en=%b busy=%b, expected 0 0", bus.fifo_wr_en, bus.busy);
        else passed++;
    endtask

    task automatic test_first_frame();
        bit found;
        int errs;
        apply_reset('0);
        bus.en_adc = 1'b1;
        ramp_on    = 1'b1;
        wait_write(found);
        total++;
        if (!found) begin
            $display("FAIL first_write_timeout: got no write in 50 cycles, expected a header");
            return;
        end
        passed++;
        capture(1024);
        total++;
        if ({frm[0], frm[1], frm[2], frm[3]} !== 32'hA55A0000)
            $display("FAIL first_header: got %h%h%h%h expected a55a0000", frm[0], frm[1], frm[2], frm[3]);
        else passed++;
        total++;
        if (frm[4] !== 8'd5)
            $display("FAIL first_payload: got %h expected 05", frm[4]);
        else passed++;
        errs = 0;
        for (int i = 0; i < 1024; i++) begin
            if (wen[i] !== 1'b1) errs++;
            if (i > 4 && frm[i] !== frm[i-1] + 8'd1) errs++;
        end
        total++;
        if (errs != 0) $display("FAIL first_ramp: got %0d bad slots expected 0", errs);
        else passed++;
        total++;
        if (bus.frame_seq !== 16'd1)
            $display("FAIL first_seq: got %h expected 0001", bus.frame_seq);
        else passed++;
    endtask

    task automatic test_back_to_back();
        bit          found;
        int          gaps;
        int          errs;
        logic [31:0] exp_hdr;
        apply_reset('0);
        bus.en_adc = 1'b1;
        ramp_on    = 1'b1;
        wait_write(found);
        total++;
        if (!found) begin
            $display("FAIL b2b_timeout: got no write in 50 cycles, expected a header");
            return;
        end
        passed++;
        capture(3072);
        gaps = 0;
        for (int i = 0; i < 3072; i++) if (wen[i] !== 1'b1) gaps++;
        total++;
        if (gaps != 0) $display("FAIL b2b_gaps: got %0d idle slots expected 0", gaps);
        else passed++;
        for (int f = 0; f < 3; f++) begin
            exp_hdr = {8'hA5, 8'h5A, 16'(f)};
            total++;
            if ({frm[f*1024], frm[f*1024+1], frm[f*1024+2], frm[f*1024+3]} !== exp_hdr)
                $display("FAIL b2b_header%0d: got %h%h%h%h expected %h", f,
                         frm[f*1024], frm[f*1024+1], frm[f*1024+2], frm[f*1024+3], exp_hdr);
            else passed++;
            errs = 0;
            for (int i = 5; i < 1024; i++)
                if (frm[f*1024+i] !== frm[f*1024+i-1] + 8'd1) errs++;
            total++;
            if (errs != 0) $display("FAIL b2b_ramp%0d: got %0d breaks expected 0", f, errs);
            else passed++;
        end
        for (int f = 0; f < 2; f++) begin
            total++;
            if (frm[1024*(f+1)+4] !== frm[1024*f+1023] + 8'd5)
                $display("FAIL b2b_hdr_drop%0d: got %h expected %h", f,
                         frm[1024*(f+1)+4], frm[1024*f+1023] + 8'd5);
            else passed++;
        end
        total++;
        if (bus.frame_seq !== 16'd3)
            $display("FAIL b2b_seq: got %h expected 0003", bus.frame_seq);
        else passed++;
    endtask

    task automatic test_wait_space();
        int writes;
        apply_reset(11'd1100);
        bus.en_adc = 1'b1;
        ramp_on    = 1'b1;
        writes     = 0;
        repeat (10) begin
            step();
            if (bus.fifo_wr_en !== 1'b0) writes++;
        end
        total++;
        if (writes != 0 || bus.drop_cnt !== 16'd9)
            $display("FAIL wait_1100: got writes=%0d drop=%0d expected writes=0 drop=9", writes, bus.drop_cnt);
        else passed++;
        bus.fifo_wr_count = 11'd1025;
        repeat (3) begin
            step();
            if (bus.fifo_wr_en !== 1'b0) writes++;
        end
        total++;
        if (writes != 0 || bus.drop_cnt !== 16'd12)
            $display("FAIL wait_1025: got writes=%0d drop=%0d expected writes=0 drop=12", writes, bus.drop_cnt);
        else passed++;
        bus.fifo_wr_count = 11'd1024;
        step();
        total++;
        if (bus.fifo_wr_en !== 1'b0)
            $display("FAIL space_lat1: got wr_en=%b expected 0", bus.fifo_wr_en);
        else passed++;
        step();
        total++;
        if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 8'hA5 || bus.drop_cnt !== 16'd12)
            $display("FAIL space_lat2: got wr_en=%b din=%h drop=%0d expected 1 a5 12",
                     bus.fifo_wr_en, bus.fifo_din, bus.drop_cnt);
        else passed++;
    endtask

    task automatic test_pad();
        bit found;
        int zeros;
        int writes;
        apply_reset('0);
        bus.en_adc = 1'b1;
        ramp_on    = 1'b1;
        wait_write(found);
        total++;
        if (!found) begin
            $display("FAIL pad_timeout: got no write in 50 cycles, expected a header");
            return;
        end
        passed++;
        frm[0] = bus.fifo_din;
        wen[0] = bus.fifo_wr_en;
        for (int i = 1; i < 1024; i++) begin
            step();
            frm[i] = bus.fifo_din;
            wen[i] = bus.fifo_wr_en;
            if (i == 103) bus.en_adc = 1'b0;
        end
        total++;
        if (frm[103] !== 8'd104)
            $display("FAIL pad_last_sample: got %h expected 68", frm[103]);
        else passed++;
        zeros = 0;
        for (int i = 104; i < 1024; i++) if (frm[i] === 8'h00 && wen[i] === 1'b1) zeros++;
        total++;
        if (zeros != 920) $display("FAIL pad_zeros: got %0d expected 920", zeros);
        else passed++;
        total++;
        if (bus.frame_seq !== 16'd1)
            $display("FAIL pad_seq: got %h expected 0001", bus.frame_seq);
        else passed++;
        writes = 0;
        repeat (20) begin
            step();
            if (bus.fifo_wr_en !== 1'b0) writes++;
        end
        total++;
        if (writes != 0 || bus.busy !== 1'b0 || bus.drop_cnt !== 16'd0)
            $display("FAIL pad_idle: got writes=%0d busy=%b drop=%0d expected 0 0 0",
                     writes, bus.busy, bus.drop_cnt);
        else passed++;
    endtask

    task automatic test_overflow();
        bit found;
        int lows;
        apply_reset('0);
        bus.en_adc = 1'b1;
        ramp_on    = 1'b1;
        wait_write(found);
        total++;
        if (!found) begin
            $display("FAIL ovf_timeout: got no write in 50 cycles, expected a header");
            return;
        end
        passed++;
        lows = 0;
        for (int t = 1; t < 1024; t++) begin
            step();
            if (bus.fifo_wr_en !== 1'b1) lows++;
            if (t == 200) bus.fifo_full = 1'b1;
            if (t == 205) bus.fifo_full = 1'b0;
        end
        total++;
        if (lows != 5) $display("FAIL ovf_suppressed: got %0d low slots expected 5", lows);
        else passed++;
        step();
        total++;
        if (bus.fifo_wr_en !== 1'b1 || bus.fifo_din !== 8'hA5)
            $display("FAIL ovf_next_hdr: got wr_en=%b din=%h expected 1 a5", bus.fifo_wr_en, bus.fifo_din);
        else passed++;
        total++;
        if (bus.overflow !== 1'b1)
            $display("FAIL ovf_flag: got %b expected 1", bus.overflow);
        else passed++;
        repeat (3) step();
        total++;
        if (bus.fifo_din !== 8'h01 || bus.overflow !== 1'b1)
            $display("FAIL ovf_sticky: got din=%h ovf=%b expected 01 1", bus.fifo_din, bus.overflow);
        else passed++;
        repeat (50) step();
    endtask

    task automatic test_reset_wrap();
        bit found;
        total++;
        if (bus.busy !== 1'b1)
            $display("FAIL rst_pre_busy: got %b expected 1", bus.busy);
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.fifo_din, bus.fifo_wr_en, bus.frame_seq, bus.drop_cnt, bus.overflow, bus.busy} !== 43'd0)
            $display("FAIL rst_async: got din=%h wr_en=%b seq=%h drop=%h ovf=%b busy=%b, expected all zero",
                     bus.fifo_din, bus.fifo_wr_en, bus.frame_seq, bus.drop_cnt, bus.overflow, bus.busy);
        else passed++;
        ramp_on    = 1'b0;
        bus.en_adc = 1'b0;
        @(negedge clk_32);
        rst = 1'b0;
        force dut.seq_q = 16'hFFFF;
        step();
        release dut.seq_q;
        step();
        bus.en_adc = 1'b1;
        ramp_on    = 1'b1;
        wait_write(found);
        total++;
        if (!found) begin
            $display("FAIL wrap_timeout: got no write in 50 cycles, expected a header");
            return;
        end
        passed++;
        capture(1024);
        total++;
        if ({frm[0], frm[1], frm[2], frm[3]} !== 32'hA55AFFFF)
            $display("FAIL wrap_header: got %h%h%h%h expected a55affff", frm[0], frm[1], frm[2], frm[3]);
        else passed++;
        total++;
        if (bus.frame_seq !== 16'h0000)
            $display("FAIL wrap_seq: got %h expected 0000", bus.frame_seq);
        else passed++;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_first_frame();
        test_back_to_back();
        test_wait_space();
        test_pad();
        test_overflow();
        test_reset_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
